// File: rtl/register_file_param_if.sv
// register_file_param_if: write, reserve and dual-read bus between decode/writeback and the register file
interface register_file_param_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic                     write_enable;
  logic [ADDR_W-1:0]        write_reg_index;
  logic signed [DATA_W-1:0] write_data;
  logic                     reserve_enable;
  logic [ADDR_W-1:0]        reserve_reg_index;
  logic                     read_enable;
  logic [ADDR_W-1:0]        read_reg_index1;
  logic [ADDR_W-1:0]        read_reg_index2;
  logic signed [DATA_W-1:0] reg_read_1;
  logic signed [DATA_W-1:0] reg_read_2;
  logic                     busy_1;
  logic                     busy_2;
  logic                     read_valid;
  logic [NUM_REGS-1:0]      pending_mask;
  modport master (
    output write_enable, write_reg_index, write_data, reserve_enable, reserve_reg_index,
    output read_enable, read_reg_index1, read_reg_index2,
    input  reg_read_1, reg_read_2, busy_1, busy_2, read_valid, pending_mask
  );
  modport slave (
    input  write_enable, write_reg_index, write_data, reserve_enable, reserve_reg_index,
    input  read_enable, read_reg_index1, read_reg_index2,
    output reg_read_1, reg_read_2, busy_1, busy_2, read_valid, pending_mask
  );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: NUM_REGS x DATA_W register file, two registered read ports, pending scoreboard
module register_file_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  register_file_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic signed [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]      pend_q, pend_d;
  logic signed [DATA_W-1:0] rd_q [2];
  logic signed [DATA_W-1:0] rd_d [2];
  logic [1:0]               busy_q, busy_d, zr, hit;
  logic                     valid_q, we_ok, rsv_ok;
  logic [ADDR_W-1:0]        ridx [2];
  assign ridx[0] = bus.read_reg_index1;
  assign ridx[1] = bus.read_reg_index2;
  assign we_ok  = bus.write_enable && !(ZERO_REG != 0 && bus.write_reg_index == '0);
  assign rsv_ok = bus.reserve_enable && !(ZERO_REG != 0 && bus.reserve_reg_index == '0);
  // reserve is applied after the write clear so a new producer keeps the bit
  always_comb begin
    pend_d = pend_q;
    if (we_ok) pend_d[bus.write_reg_index] = 1'b0;
    if (rsv_ok) pend_d[bus.reserve_reg_index] = 1'b1;
  end
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      zr[p]     = ZERO_REG != 0 && ridx[p] == '0;
      hit[p]    = BYPASS != 0 && we_ok && bus.write_reg_index == ridx[p];
      rd_d[p]   = zr[p] ? '0 : hit[p] ? bus.write_data : regs_q[ridx[p]];
      busy_d[p] = !zr[p] && (hit[p] ? pend_d[ridx[p]] : pend_q[ridx[p]]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q  <= '0;
      rd_q[0] <= '0;
      rd_q[1] <= '0;
      busy_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (we_ok) regs_q[bus.write_reg_index] <= bus.write_data;
      pend_q  <= pend_d;
      valid_q <= bus.read_enable;
      if (bus.read_enable) begin
        rd_q   <= rd_d;
        busy_q <= busy_d;
      end
    end
  end
  assign bus.reg_read_1   = rd_q[0];
  assign bus.reg_read_2   = rd_q[1];
  assign bus.busy_1       = busy_q[0];
  assign bus.busy_2       = busy_q[1];
  assign bus.read_valid   = valid_q;
  assign bus.pending_mask = pend_q;
endmodule
